data_memory_arbiter: RTL

//  Shares the single-port data memory between two requesters: M0 (core load/store port) and M1 (loader/debug port).

---
 rtl/data_memory_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between a core
// port (M0) and a loader/debug port (M1), one latched transaction at a time.

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 16
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module data_memory_arbiter #(
    parameter int ADDRESS_WIDTH = `ADDRESS_SIZE,
    parameter int DATA_WIDTH    = `DATA_SIZE,
    parameter int DEPTH         = 256,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     m0_req,
    input  logic                     m0_write,
    input  logic [ADDRESS_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0]    m0_wdata,
    output logic                     m0_ready,
    output logic [DATA_WIDTH-1:0]    m0_rdata,
    input  logic                     m1_req,
    input  logic                     m1_write,
    input  logic [ADDRESS_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0]    m1_wdata,
    output logic                     m1_ready,
    output logic [DATA_WIDTH-1:0]    m1_rdata,
    output logic                     error,
    output logic [1:0]               grant,
    output logic                     read,
    output logic                     write,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0]    data_in,
    input  logic [DATA_WIDTH-1:0]    data_out,
    output logic [2:0]               state_dbg
);

    // Handshake: a requester raises mX_req with its op and holds it; the
    // transaction is latched on selection and mX_ready pulses for exactly one
    // cycle when it completes. Dropping req early never aborts a transaction.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [2:0]             WAIT_LOAD = 3'(READ_LATENCY - 1);

    state_t                   state_q, state_d;
    logic                     last_grant_q;   // 1 = M1 was granted last
    logic [1:0]               grant_q;
    logic                     op_write_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     err_q;
    logic [2:0]               wait_cnt_q;

    logic sel_m0, sel_m1, in_range;

    // On a tie the master that was not granted last wins.
    assign sel_m0   = m0_req && (!m1_req || last_grant_q);
    assign sel_m1   = m1_req && (!m0_req || !last_grant_q);
    assign in_range = {1'b0, addr_q} < DEPTH_W;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sel_m0 || sel_m1) state_d = S_ISSUE;
            S_ISSUE: state_d = (op_write_q || !in_range) ? S_DONE : S_WAIT;
            S_WAIT:  if (wait_cnt_q == 3'd0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            wait_cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sel_m0 || sel_m1) begin
                        grant_q      <= sel_m1 ? 2'b10 : 2'b01;
                        last_grant_q <= sel_m1;
                        op_write_q   <= sel_m1 ? m1_write   : m0_write;
                        addr_q       <= sel_m1 ? m1_address : m0_address;
                        wdata_q      <= sel_m1 ? m1_wdata   : m0_wdata;
                        rdata_q      <= '0;
                        err_q        <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    err_q      <= !in_range;
                    wait_cnt_q <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (wait_cnt_q == 3'd0) rdata_q <= data_out;
                    else                    wait_cnt_q <= wait_cnt_q - 3'd1;
                end
                S_DONE: begin
                    grant_q <= 2'b00;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Strobes are decoded from state so a reset drops them immediately.
    always_comb begin
        read     = (state_q == S_ISSUE) && !op_write_q && in_range;
        write    = (state_q == S_ISSUE) &&  op_write_q && in_range;
        address  = addr_q;
        data_in  = wdata_q;
        grant    = grant_q;
        m0_ready = (state_q == S_DONE) && grant_q[0];
        m1_ready = (state_q == S_DONE) && grant_q[1];
        m0_rdata = m0_ready ? rdata_q : '0;
        m1_rdata = m1_ready ? rdata_q : '0;
        error    = (state_q == S_DONE) && err_q;
        state_dbg = state_q;
    end

endmodule
